apb_master: RTL

- APB3 initiator that turns a simple command valid/ready request into one APB transfer: SETUP phase, then ACCESS phase, then completion.
- Drives the `apb_slave` bus interface and replaces the hand-written task stimulus with a reusable synthesizable requester.
- Returns read data and error status on a single-cycle response strobe.
- Sits between a local controller (CPU/bridge/test sequencer) and one APB completer.

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_master.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB3 requester.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_master.sv
// APB3 initiator: turns one command handshake into one SETUP/ACCESS transfer
// and reports completion on a single-cycle response strobe.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);

    apb_state_t        state_r;
    apb_state_t        state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              accept_s;
    logic              done_s;
    logic              tmo_s;

    logic              cmd_ready_r;
    logic              psel_r;
    logic              penable_r;
    logic              pwrite_r;
    logic [ADDR_W-1:0] paddr_r;
    logic [DATA_W-1:0] pwdata_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;
    logic              rsp_timeout_r;

    assign cnt_inc_s = cnt_r + CNT_W'(1);

    // Next-state, wait counter and completion decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        done_s      = 1'b0;
        tmo_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    accept_s    = 1'b1;
                    cnt_nxt_s   = '0;
                    state_nxt_s = SETUP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                state_nxt_s = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    done_s      = 1'b1;
                    state_nxt_s = IDLE;
                end else if ((TIMEOUT != 0) && (cnt_inc_s == TMO_LIMIT)) begin
                    // this edge closes the TIMEOUT-th ACCESS cycle with pready low
                    tmo_s       = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    cnt_nxt_s   = cnt_inc_s;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register and registered APB / response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            cmd_ready_r   <= 1'b1;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= '0;
            pwdata_r      <= '0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= '0;
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            cmd_ready_r <= (state_nxt_s == IDLE);
            psel_r      <= (state_nxt_s != IDLE);
            penable_r   <= (state_nxt_s == ACCESS);
            rsp_valid_r <= done_s | tmo_s;
            if (accept_s) begin
                paddr_r  <= cmd_addr;
                pwrite_r <= cmd_write;
                pwdata_r <= cmd_wdata;
            end
            if (done_s) begin
                rsp_rdata_r   <= pwrite_r ? '0 : prdata;
                rsp_err_r     <= pslverr;
                rsp_timeout_r <= 1'b0;
            end else if (tmo_s) begin
                rsp_rdata_r   <= '0;
                rsp_err_r     <= 1'b1;
                rsp_timeout_r <= 1'b1;
            end
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign psel        = psel_r;
    assign penable     = penable_r;
    assign pwrite      = pwrite_r;
    assign paddr       = paddr_r;
    assign pwdata      = pwdata_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_err     = rsp_err_r;
    assign rsp_timeout = rsp_timeout_r;

endmodule
